imem_loader: RTL and testbench

- Boot-time program loader: the writing end of the instruction-memory load path.
- Receives a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word into instruction memory through a single-port write interface.
- Holds the CPU core in reset until a complete frame has loaded and its checksum verifies.

---
 rtl/imem_loader_if.sv | 12 +
 rtl/imem_loader.sv | 114 +++++++++++
 tb/tb_imem_loader.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input and instruction-memory write bus of the loader
// Carries the byte stream into the loader and the word writes out of it.
interface imem_loader_if #(parameter int ADDR_WIDTH = 8);
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;
    modport master (output in_valid, in_data, input in_ready, imem_we, imem_addr, imem_wdata);
    modport slave  (input in_valid, in_data, output in_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot-time loader assembling framed LE bytes into imem words
// Holds the core in reset until the frame has loaded and its checksum matches.
module imem_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    imem_loader_if.slave  bus,
    output logic          cpu_reset,
    output logic          load_done,
    output logic          load_error
);
    typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA, WRITE, CSUM, DONE, ERROR} state_t;
    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;
    state_t                state_q, state_d;
    logic [15:0]           count_q, count_d;
    logic [15:0]           word_idx_q, word_idx_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [31:0]           word_q, word_d;
    logic [7:0]            csum_q, csum_d;
    logic                  in_ready_q, in_ready_d;
    logic                  imem_we_q, imem_we_d;
    logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]           imem_wdata_q, imem_wdata_d;
    logic                  cpu_reset_q, cpu_reset_d;
    logic                  load_done_q, load_done_d;
    logic                  load_error_q, load_error_d;
    logic                  fire;
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        word_idx_d   = word_idx_q;
        byte_idx_d   = byte_idx_q;
        word_d       = word_q;
        csum_d       = csum_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        fire         = bus.in_valid && in_ready_q;
        case (state_q)
            LEN_LO: if (fire) begin
                count_d[7:0] = bus.in_data;
                state_d      = LEN_HI;
            end
            LEN_HI: if (fire) begin
                count_d[15:8] = bus.in_data;
                word_idx_d    = '0;
                byte_idx_d    = '0;
                state_d       = ({1'b0, count_d} > MAX_WORDS) ? ERROR :
                                (count_d == 16'd0) ? CSUM : DATA;
            end
            DATA: if (fire) begin
                word_d[{byte_idx_q, 3'b000} +: 8] = bus.in_data;
                csum_d     = csum_q ^ bus.in_data;
                byte_idx_d = byte_idx_q + 2'd1;
                // The write is prepared here so it is already on the bus during WRITE.
                if (byte_idx_q == 2'd3) begin
                    state_d      = WRITE;
                    imem_we_d    = 1'b1;
                    imem_addr_d  = word_idx_q[ADDR_WIDTH-1:0];
                    imem_wdata_d = word_d;
                end
            end
            WRITE: begin
                word_idx_d = word_idx_q + 16'd1;
                state_d    = (word_idx_d == count_q) ? CSUM : DATA;
            end
            CSUM: if (fire) state_d = (bus.in_data == csum_q) ? DONE : ERROR;
            default: ;
        endcase
        in_ready_d   = state_d inside {LEN_LO, LEN_HI, DATA, CSUM};
        cpu_reset_d  = state_d != DONE;
        load_done_d  = state_d == DONE;
        load_error_d = state_d == ERROR;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= LEN_LO;
            count_q      <= '0;
            word_idx_q   <= '0;
            byte_idx_q   <= '0;
            word_q       <= '0;
            csum_q       <= '0;
            in_ready_q   <= 1'b1;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_reset_q  <= 1'b1;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            word_idx_q   <= word_idx_d;
            byte_idx_q   <= byte_idx_d;
            word_q       <= word_d;
            csum_q       <= csum_d;
            in_ready_q   <= in_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_reset_q  <= cpu_reset_d;
            load_done_q  <= load_done_d;
            load_error_q <= load_error_d;
        end
    end
    assign bus.in_ready   = in_ready_q;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign cpu_reset      = cpu_reset_q;
    assign load_done      = load_done_q;
    assign load_error     = load_error_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed frames against imem_loader with immediate assertions
module tb_imem_loader;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic cpu_reset, load_done, load_error;
    imem_loader_if #(.ADDR_WIDTH(8)) bus();
    imem_loader #(.ADDR_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .cpu_reset(cpu_reset), .load_done(load_done), .load_error(load_error)
    );
    always #5 clk = ~clk;
    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    logic prev_we = 1'b0;
    logic [7:0]  wa[$];
    logic [31:0] wd[$];
    logic [7:0]  frame1 [11] = '{8'h02, 8'h00, 8'h13, 8'h02, 8'h00, 8'h01,
                                 8'h93, 8'h00, 8'h10, 8'h00, 8'h93};
    logic [31:0] exp_w [256];
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (!reset && bus.imem_we) begin
            wa.push_back(bus.imem_addr);
            wd.push_back(bus.imem_wdata);
            chk("we_ready_low", {31'd0, bus.in_ready}, 32'd0);
            chk("we_single", {31'd0, prev_we}, 32'd0);
        end
        if (!reset) chk("done_err_excl", {31'd0, load_done & load_error}, 32'd0);
        prev_we <= reset ? 1'b0 : bus.imem_we;
    end
    task automatic send(input logic [7:0] b);
        logic r;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int i = 0; i < 40; i++) begin
            r = bus.in_ready;
            @(posedge clk);
            @(negedge clk);
            if (r) return;
        end
        n_chk++;
        n_fail++;
        $error("FAIL accept_timeout: byte %h observed not accepted expected accepted", b);
    endtask
    task automatic send_bubbly(input logic [7:0] b);
        if (!bus.in_ready) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'($urandom);
        end else bus.in_valid = 1'b0;
        @(negedge clk);
        send(b);
    endtask
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        wa.delete();
        wd.delete();
    endtask
    task automatic send_frame1(input bit bubbly, input logic [7:0] last);
        for (int i = 0; i < 10; i++) if (bubbly) send_bubbly(frame1[i]); else send(frame1[i]);
        chk("pre_csum_done", {31'd0, load_done}, 32'd0);
        if (bubbly) send_bubbly(last); else send(last);
        bus.in_valid = 1'b0;
        #1;
    endtask
    task automatic check_two_writes(input string tag);
        chk({tag, "_nwr"}, wa.size(), 2);
        if (wa.size() == 2) begin
            chk({tag, "_a0"}, {24'd0, wa[0]}, 32'd0);
            chk({tag, "_d0"}, wd[0], 32'h01000213);
            chk({tag, "_a1"}, {24'd0, wa[1]}, 32'd1);
            chk({tag, "_d1"}, wd[1], 32'h00100093);
        end
    endtask
    task automatic stray_bytes(input string tag, input int nwr);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_data = 8'($urandom);
            @(negedge clk);
            chk({tag, "_ready"}, {31'd0, bus.in_ready}, 32'd0);
        end
        bus.in_valid = 1'b0;
        chk({tag, "_nwr"}, wa.size(), nwr);
    endtask
    initial begin
        int c0, mism;
        logic [7:0] b, cs;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        #2 reset = 1'b1;
        do_reset();
        chk("rst_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_we", {31'd0, bus.imem_we}, 32'd0);
        chk("rst_addr", {24'd0, bus.imem_addr}, 32'd0);
        chk("rst_wdata", bus.imem_wdata, 32'd0);
        chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("rst_done", {31'd0, load_done}, 32'd0);
        chk("rst_error", {31'd0, load_error}, 32'd0);
        // Two-word load, back to back
        c0 = cyc;
        send_frame1(1'b0, 8'h93);
        chk("t1_cycles", cyc - c0, 13);
        check_two_writes("t1");
        chk("t1_done", {31'd0, load_done}, 32'd1);
        chk("t1_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        chk("t1_error", {31'd0, load_error}, 32'd0);
        stray_bytes("t1_stray", 2);
        chk("t1_done_hold", {31'd0, load_done}, 32'd1);
        // Bad checksum
        do_reset();
        send_frame1(1'b0, 8'h92);
        check_two_writes("t2");
        chk("t2_error", {31'd0, load_error}, 32'd1);
        chk("t2_done", {31'd0, load_done}, 32'd0);
        chk("t2_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        stray_bytes("t2_stray", 2);
        chk("t2_error_hold", {31'd0, load_error}, 32'd1);
        // Empty frames
        do_reset();
        send(8'h00); send(8'h00);
        chk("t3_ready_csum", {31'd0, bus.in_ready}, 32'd1);
        send(8'h00);
        bus.in_valid = 1'b0;
        #1;
        chk("t3_done", {31'd0, load_done}, 32'd1);
        chk("t3_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        chk("t3_nwr", wa.size(), 0);
        do_reset();
        send(8'h00); send(8'h00); send(8'h05);
        bus.in_valid = 1'b0;
        #1;
        chk("t3b_error", {31'd0, load_error}, 32'd1);
        chk("t3b_done", {31'd0, load_done}, 32'd0);
        // Oversize frame
        do_reset();
        send(8'h01); send(8'h01);
        bus.in_valid = 1'b0;
        #1;
        chk("t4_error", {31'd0, load_error}, 32'd1);
        chk("t4_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("t4_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        stray_bytes("t4_stray", 0);
        // Full-memory frame of 256 words
        do_reset();
        send(8'h00); send(8'h01);
        cs = 8'h00;
        for (int k = 0; k < 1024; k++) begin
            b = 8'(k * 7 + 3);
            cs ^= b;
            exp_w[k / 4][8 * (k % 4) +: 8] = b;
            send(b);
        end
        send(cs);
        bus.in_valid = 1'b0;
        #1;
        chk("t4b_nwr", wa.size(), 256);
        mism = 0;
        for (int i = 0; i < wa.size() && i < 256; i++)
            if (wa[i] !== 8'(i) || wd[i] !== exp_w[i]) mism++;
        chk("t4b_mismatches", mism, 0);
        if (wa.size() > 0) chk("t4b_last_addr", {24'd0, wa[wa.size() - 1]}, 32'hFF);
        chk("t4b_done", {31'd0, load_done}, 32'd1);
        chk("t4b_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        // Bubbles and stray bytes during WRITE
        do_reset();
        send_frame1(1'b1, 8'h93);
        check_two_writes("t5");
        chk("t5_done", {31'd0, load_done}, 32'd1);
        chk("t5_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        // Asynchronous reset mid-load, then reload
        do_reset();
        send(8'h02); send(8'h00); send(8'h13); send(8'h02);
        chk("t6_pre_ready", {31'd0, bus.in_ready}, 32'd1);
        #2 reset = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        chk("t6_async_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("t6_async_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("t6_async_we", {31'd0, bus.imem_we}, 32'd0);
        chk("t6_async_done", {31'd0, load_done}, 32'd0);
        chk("t6_async_error", {31'd0, load_error}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        wa.delete();
        wd.delete();
        send_frame1(1'b0, 8'h93);
        check_two_writes("t6");
        chk("t6_done", {31'd0, load_done}, 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
